// File: rtl/channel_rx_pkg.sv
// Shared types, default parameters and helpers for the receive-side CDR.
package channel_rx_pkg;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      TRACK   = 2'd1,
      LOCKED  = 2'd2
   } rx_state_e;

   localparam int unsigned DEF_LEVEL_W    = 8;
   localparam int unsigned DEF_THRESHOLD  = 128;
   localparam int unsigned DEF_HYST       = 8;
   localparam int unsigned DEF_OSR        = 8;
   localparam int unsigned DEF_LOCK_TOL   = 1;
   localparam int unsigned DEF_LOCK_COUNT = 16;
   localparam int unsigned DEF_MAX_RUN    = 64;

   // An edge is well timed when its phase sits within tol of 0, measured circularly.
   function automatic logic good_edge(input int unsigned ph,
                                      input int unsigned osr,
                                      input int unsigned tol);
      return (ph <= tol) || (ph >= osr - tol);
   endfunction

endpackage

// File: rtl/channel_rx_cdr_slicer.sv
// Hysteresis slicer: turns the quantized amplitude into a registered bit decision.
module level_slicer
   import channel_rx_pkg::*;
#(
   parameter int unsigned LEVEL_W   = DEF_LEVEL_W,
   parameter int unsigned THRESHOLD = DEF_THRESHOLD,
   parameter int unsigned HYST      = DEF_HYST
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [LEVEL_W-1:0] level_in,
   output logic               slice,
   output logic               dec_next
);

   // One spare bit so a high threshold beyond full scale simply never trips.
   localparam logic [LEVEL_W:0] HI_LVL = (LEVEL_W+1)'(THRESHOLD + HYST);
   localparam logic [LEVEL_W:0] LO_LVL = (LEVEL_W+1)'(THRESHOLD - HYST);

   logic [LEVEL_W:0] w_level;
   logic             r_slice;

   assign w_level = {1'b0, level_in};

   // Decide outside the hysteresis band, otherwise keep the previous decision.
   always_comb begin
      dec_next = r_slice;
      if (w_level >= HI_LVL) begin
         dec_next = 1'b1;
      end else if (w_level <= LO_LVL) begin
         dec_next = 1'b0;
      end
   end

   // Slice register follows the decision on valid samples only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slice <= 1'b0;
      end else if (en) begin
         r_slice <= dec_next;
      end
   end

   assign slice = r_slice;

endmodule

// File: rtl/channel_rx_cdr.sv
// Oversampling CDR: hysteresis slicer, edge-realigned phase counter,
// run-length loss-of-signal detector and a lock FSM.
module channel_rx_cdr
   import channel_rx_pkg::*;
#(
   parameter int unsigned LEVEL_W    = DEF_LEVEL_W,
   parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
   parameter int unsigned HYST       = DEF_HYST,
   parameter int unsigned OSR        = DEF_OSR,
   parameter int unsigned LOCK_TOL   = DEF_LOCK_TOL,
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int unsigned MAX_RUN    = DEF_MAX_RUN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [LEVEL_W-1:0] level_in,
   output logic               bit_out,
   output logic               bit_valid,
   output logic               locked,
   output logic               edge_err
);

   localparam int unsigned PH_W  = $clog2(OSR);
   localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
   localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OSR / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_COUNT - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

   logic             w_slice;
   logic             w_dec_next;
   logic             w_edge;
   logic             w_wrap;
   logic             w_good;
   logic             w_sample;
   logic             w_run_hit;

   logic [PH_W-1:0]  r_ph;
   logic [RUN_W-1:0] r_run;
   logic [CNT_W-1:0] r_cnt;
   rx_state_e        r_state;
   rx_state_e        w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_err_nxt;

   logic             r_bit_out;
   logic             r_bit_valid;
   logic             r_edge_err;

   level_slicer #(
      .LEVEL_W   (LEVEL_W),
      .THRESHOLD (THRESHOLD),
      .HYST      (HYST)
   ) u_slicer (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .level_in (level_in),
      .slice    (w_slice),
      .dec_next (w_dec_next)
   );

   assign w_edge    = en && (w_dec_next != w_slice);
   assign w_wrap    = en && !w_edge && (r_ph == PH_LAST);
   assign w_run_hit = w_wrap && (r_run == RUN_LAST);
   assign w_good    = good_edge(32'(r_ph), OSR, LOCK_TOL);
   assign w_sample  = en && (r_ph == PH_MID) && (r_state != ACQUIRE);

   // Phase restarts at 1 after an edge (the edge sample is phase 0); run
   // length counts UI wraps since the last edge and restarts on loss of signal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph  <= '0;
         r_run <= '0;
      end else if (en) begin
         if (w_edge) begin
            r_ph <= PH_W'(1);
         end else if (w_wrap) begin
            r_ph <= '0;
         end else begin
            r_ph <= r_ph + 1'b1;
         end

         if (w_edge || w_run_hit) begin
            r_run <= '0;
         end else if (w_wrap) begin
            r_run <= r_run + 1'b1;
         end
      end
   end

   // Lock FSM: loss of signal overrides everything, otherwise react to edges.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = 1'b0;
      if (w_run_hit) begin
         w_state_nxt = ACQUIRE;
         w_cnt_nxt   = '0;
      end else if (w_edge) begin
         case (r_state)
            ACQUIRE: begin
               w_state_nxt = TRACK;
               w_cnt_nxt   = '0;
            end
            TRACK: begin
               if (w_good) begin
                  if (r_cnt == CNT_LAST) begin
                     w_state_nxt = LOCKED;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end else begin
                  w_cnt_nxt = '0;
               end
            end
            LOCKED: begin
               if (!w_good) begin
                  w_state_nxt = TRACK;
                  w_cnt_nxt   = '0;
                  w_err_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ACQUIRE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // FSM state and good-edge counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACQUIRE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Output strobes are qualified by en through w_sample/w_edge, so they drop on idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_edge_err  <= 1'b0;
      end else begin
         r_bit_valid <= w_sample;
         r_edge_err  <= w_err_nxt;
         if (w_sample) begin
            r_bit_out <= w_slice;
         end
      end
   end

   assign bit_out   = r_bit_out;
   assign bit_valid = r_bit_valid;
   assign edge_err  = r_edge_err;
   assign locked    = (r_state == LOCKED);

endmodule
